// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle controller: FSM states, RV64 opcode and
// funct fields, ALU operation codes and decoded instruction classes.
package multicycle_control_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OPC_R   = 7'b0110011;
    localparam logic [6:0] OPC_I   = 7'b0010011;
    localparam logic [6:0] OPC_LD  = 7'b0000011;
    localparam logic [6:0] OPC_SD  = 7'b0100011;
    localparam logic [6:0] OPC_BEQ = 7'b1100011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_D    = 3'b011;
    localparam logic [2:0] F3_BEQ  = 3'b000;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;

    localparam logic [2:0] CLS_NONE = 3'd0;
    localparam logic [2:0] CLS_R    = 3'd1;
    localparam logic [2:0] CLS_I    = 3'd2;
    localparam logic [2:0] CLS_LD   = 3'd3;
    localparam logic [2:0] CLS_SD   = 3'd4;
    localparam logic [2:0] CLS_BEQ  = 3'd5;

    // IR value after reset: addi x0,x0,0 (nop)
    localparam logic [31:0] IR_RESET = 32'h00000013;

    // True for classes that need a data-memory phase
    function automatic logic is_mem_class(input logic [2:0] cls);
        return (cls == CLS_LD) || (cls == CLS_SD);
    endfunction

endpackage

// File: rtl/multicycle_control_alu_decode.sv
// Combinational instruction decode: IR -> ALU op, ALU B-source select,
// instruction class and legality.
module multicycle_control_alu_decode
    import multicycle_control_pkg::*;
(
    input  logic [31:0] instruction,
    output logic [3:0]  alu_operation,
    output logic        alusrc,
    output logic [2:0]  op_class,
    output logic        legal
);

    logic [6:0] opcode_s;
    logic [2:0] funct3_s;
    logic [6:0] funct7_s;
    logic       unused_fields_s;

    assign opcode_s = instruction[6:0];
    assign funct3_s = instruction[14:12];
    assign funct7_s = instruction[31:25];
    assign unused_fields_s = ^{instruction[24:15], instruction[11:7]};

    // Classify the instruction and select ALU op / operand source
    always_comb begin
        alu_operation = ALU_ADD;
        alusrc        = 1'b0;
        op_class      = CLS_NONE;
        legal         = 1'b0;
        case (opcode_s)
            OPC_R: begin
                op_class = CLS_R;
                if (funct7_s == F7_BASE) begin
                    case (funct3_s)
                        F3_ADD:  begin alu_operation = ALU_ADD; legal = 1'b1; end
                        F3_AND:  begin alu_operation = ALU_AND; legal = 1'b1; end
                        F3_OR:   begin alu_operation = ALU_OR;  legal = 1'b1; end
                        default: legal = 1'b0;
                    endcase
                end else if ((funct7_s == F7_SUB) && (funct3_s == F3_ADD)) begin
                    alu_operation = ALU_SUB;
                    legal         = 1'b1;
                end else begin
                    legal = 1'b0;
                end
            end
            OPC_I: begin
                op_class = CLS_I;
                alusrc   = 1'b1;
                case (funct3_s)
                    F3_ADD:  begin alu_operation = ALU_ADD; legal = 1'b1; end
                    F3_AND:  begin alu_operation = ALU_AND; legal = 1'b1; end
                    F3_OR:   begin alu_operation = ALU_OR;  legal = 1'b1; end
                    default: legal = 1'b0;
                endcase
            end
            OPC_LD: begin
                op_class = CLS_LD;
                alusrc   = 1'b1;
                legal    = (funct3_s == F3_D);
            end
            OPC_SD: begin
                op_class = CLS_SD;
                alusrc   = 1'b1;
                legal    = (funct3_s == F3_D);
            end
            OPC_BEQ: begin
                op_class      = CLS_BEQ;
                alu_operation = ALU_SUB;
                legal         = (funct3_s == F3_BEQ);
            end
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle controller: FETCH/DECODE/EXEC/MEM/WB with a sticky TRAP state
// for illegal instructions. Holds the IR and the retired-instruction counter.
module multicycle_control
    import multicycle_control_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ready,
    output logic [31:0] instruction,
    input  logic        zero,
    output logic        memtoreg,
    output logic        pcsrc,
    output logic        alusrc,
    output logic        regwrite,
    output logic        pc_en,
    output logic [3:0]  alu_operation,
    output logic        illegal,
    output logic [31:0] instret
);

    state_t      state_r;
    state_t      next_s;
    logic [31:0] ir_r;
    logic [31:0] instret_r;

    logic [3:0]  dec_op_s;
    logic        dec_alusrc_s;
    logic [2:0]  dec_class_s;
    logic        dec_legal_s;

    logic        imem_req_s, dmem_req_s, dmem_we_s, memtoreg_s;
    logic        pcsrc_s, alusrc_s, regwrite_s, pc_en_s;
    logic [3:0]  alu_op_s;

    multicycle_control_alu_decode u_alu_decode (
        .instruction   (ir_r),
        .alu_operation (dec_op_s),
        .alusrc        (dec_alusrc_s),
        .op_class      (dec_class_s),
        .legal         (dec_legal_s)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_FETCH;
        end else begin
            state_r <= next_s;
        end
    end

    // Instruction register: loads only on an accepted fetch
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ir_r <= IR_RESET;
        end else if ((state_r == ST_FETCH) && imem_ready) begin
            ir_r <= imem_rdata;
        end else begin
            ir_r <= ir_r;
        end
    end

    // Retired-instruction counter; pc_en marks exactly one retire, wraps freely
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instret_r <= 32'd0;
        end else if (pc_en_s) begin
            instret_r <= instret_r + 32'd1;
        end else begin
            instret_r <= instret_r;
        end
    end

    // Next-state logic
    always_comb begin
        next_s = state_r;
        case (state_r)
            ST_FETCH:  next_s = imem_ready ? ST_DECODE : ST_FETCH;
            ST_DECODE: next_s = dec_legal_s ? ST_EXEC : ST_TRAP;
            ST_EXEC: begin
                if (dec_class_s == CLS_BEQ) begin
                    next_s = ST_FETCH;
                end else if (is_mem_class(dec_class_s)) begin
                    next_s = ST_MEM;
                end else begin
                    next_s = ST_WB;
                end
            end
            ST_MEM:    next_s = dmem_ready ? ST_FETCH : ST_MEM;
            ST_WB:     next_s = ST_FETCH;
            ST_TRAP:   next_s = ST_TRAP;
            default:   next_s = ST_FETCH;
        endcase
    end

    // Output decode; the fetch request is gated by reset so nothing is driven while held
    always_comb begin
        imem_req_s = 1'b0;
        dmem_req_s = 1'b0;
        dmem_we_s  = 1'b0;
        memtoreg_s = 1'b0;
        pcsrc_s    = 1'b0;
        alusrc_s   = 1'b0;
        regwrite_s = 1'b0;
        pc_en_s    = 1'b0;
        alu_op_s   = 4'b0000;
        case (state_r)
            ST_FETCH:  imem_req_s = reset;
            ST_DECODE: imem_req_s = 1'b0;
            ST_EXEC: begin
                alu_op_s = dec_op_s;
                alusrc_s = dec_alusrc_s;
                if (dec_class_s == CLS_BEQ) begin
                    pc_en_s = 1'b1;
                    pcsrc_s = zero;
                end else begin
                    pc_en_s = 1'b0;
                end
            end
            ST_MEM: begin
                alu_op_s   = dec_op_s;
                alusrc_s   = dec_alusrc_s;
                dmem_req_s = 1'b1;
                dmem_we_s  = (dec_class_s == CLS_SD);
                if (dmem_ready) begin
                    pc_en_s    = 1'b1;
                    regwrite_s = (dec_class_s == CLS_LD);
                    memtoreg_s = (dec_class_s == CLS_LD);
                end else begin
                    pc_en_s = 1'b0;
                end
            end
            ST_WB: begin
                alu_op_s   = dec_op_s;
                alusrc_s   = dec_alusrc_s;
                regwrite_s = 1'b1;
                pc_en_s    = 1'b1;
            end
            ST_TRAP:   pc_en_s = 1'b0;
            default:   pc_en_s = 1'b0;
        endcase
    end

    assign imem_req      = imem_req_s;
    assign dmem_req      = dmem_req_s;
    assign dmem_we       = dmem_we_s;
    assign memtoreg      = memtoreg_s;
    assign pcsrc         = pcsrc_s;
    assign alusrc        = alusrc_s;
    assign regwrite      = regwrite_s;
    assign pc_en         = pc_en_s;
    assign alu_operation = alu_op_s;
    assign instruction   = ir_r;
    assign instret       = instret_r;
    assign illegal       = (state_r == ST_TRAP);

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control. Inputs change on the
// falling edge; outputs are sampled 1 ns later, away from the rising edge.
module tb_multicycle_control;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ready;
    logic [31:0] instruction;
    logic        zero;
    logic        memtoreg;
    logic        pcsrc;
    logic        alusrc;
    logic        regwrite;
    logic        pc_en;
    logic [3:0]  alu_operation;
    logic        illegal;
    logic [31:0] instret;

    int checks_s = 0;
    int errors_s = 0;

    localparam logic [31:0] I_ADD   = 32'h002081B3; // add  x3,x1,x2
    localparam logic [31:0] I_SUB   = 32'h40208133; // sub  x2,x1,x2
    localparam logic [31:0] I_ORI   = 32'h00506093; // ori  x1,x0,5
    localparam logic [31:0] I_BEQ   = 32'h00208063; // beq  x1,x2,0
    localparam logic [31:0] I_LD    = 32'h00013083; // ld   x1,0(x2)
    localparam logic [31:0] I_SD    = 32'h00113023; // sd   x1,0(x2)
    localparam logic [31:0] I_LW    = 32'h00012083; // lw: funct3 010, not supported
    localparam logic [31:0] I_ONES  = 32'hFFFFFFFF;
    localparam logic [31:0] IR_NOP  = 32'h00000013;

    multicycle_control dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req      (imem_req),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_ready    (dmem_ready),
        .instruction   (instruction),
        .zero          (zero),
        .memtoreg      (memtoreg),
        .pcsrc         (pcsrc),
        .alusrc        (alusrc),
        .regwrite      (regwrite),
        .pc_en         (pc_en),
        .alu_operation (alu_operation),
        .illegal       (illegal),
        .instret       (instret)
    );

    // 100 MHz clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_s++;
        if (got !== exp) begin
            errors_s++;
            $display("FAIL %s: got 0x%08h want 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Present one instruction on a zero-wait fetch; returns in the EXEC (or TRAP) cycle
    task automatic do_fetch(input logic [31:0] ins);
        #1;
        check("fetch_req", {31'd0, imem_req}, 32'd1);
        imem_ready = 1'b1;
        imem_rdata = ins;
        step();
        // DECODE: a stray ready with junk data must not reload the IR
        imem_rdata = 32'hDEADBEEF;
        #1;
        check("ir_latch", instruction, ins);
        check("decode_quiet", {28'd0, pc_en, regwrite, imem_req, dmem_req}, 32'd0);
        step();
        imem_ready = 1'b0;
        imem_rdata = 32'd0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        check("rst_ir", instruction, IR_NOP);
        check("rst_outs", {23'd0, imem_req, dmem_req, dmem_we, memtoreg, pcsrc,
                           alusrc, regwrite, pc_en, illegal}, 32'd0);
        check("rst_alu", {28'd0, alu_operation}, 32'd0);
        check("rst_instret", instret, 32'd0);
        step();
        reset = 1'b1;
        #1;
        check("post_rst_req", {31'd0, imem_req}, 32'd1);
    endtask

    initial begin
        reset      = 1'b0;
        imem_ready = 1'b0;
        imem_rdata = 32'd0;
        dmem_ready = 1'b0;
        zero       = 1'b0;
        @(negedge clk);
        do_reset();

        // add: EXEC cycle 3, WB cycle 4
        do_fetch(I_ADD);
        #1;
        check("add_ir_hold", instruction, I_ADD);
        check("add_exec_alu", {28'd0, alu_operation}, 32'h2);
        check("add_exec_src", {30'd0, alusrc, pc_en}, 32'd0);
        step();
        #1;
        check("add_wb", {28'd0, pc_en, regwrite, memtoreg, pcsrc}, 32'b1100);
        check("add_wb_alu", {28'd0, alu_operation}, 32'h2);
        step();
        #1;
        check("add_instret", instret, 32'd1);
        check("add_pc_en_low", {31'd0, pc_en}, 32'd0);

        // sub
        do_fetch(I_SUB);
        #1;
        check("sub_exec_alu", {28'd0, alu_operation}, 32'h6);
        step();
        #1;
        check("sub_wb", {28'd0, pc_en, regwrite, memtoreg, alusrc}, 32'b1100);
        step();

        // ori: immediate operand
        do_fetch(I_ORI);
        #1;
        check("ori_exec", {27'd0, alusrc, alu_operation}, {27'd0, 1'b1, 4'b0001});
        step();
        #1;
        check("ori_wb", {27'd0, pc_en, regwrite, alusrc, alu_operation}, {27'd0, 3'b111, 4'b0001});
        step();
        #1;
        check("ori_instret", instret, 32'd3);

        // beq taken: retires in EXEC (cycle 3)
        do_fetch(I_BEQ);
        zero = 1'b1;
        #1;
        check("beq_t_exec", {26'd0, pc_en, pcsrc, regwrite, alusrc, alu_operation},
              {26'd0, 4'b1100, 4'b0110});
        step();
        zero = 1'b0;
        #1;
        check("beq_t_next", {30'd0, imem_req, pc_en}, 32'b10);
        check("beq_t_instret", instret, 32'd4);

        // beq not taken
        do_fetch(I_BEQ);
        #1;
        check("beq_nt_exec", {28'd0, pc_en, pcsrc, regwrite, alusrc}, 32'b1000);
        step();
        #1;
        check("beq_nt_instret", instret, 32'd5);

        // ld with three wait cycles: dmem_req high four cycles, retire on the fourth only
        do_fetch(I_LD);
        #1;
        check("ld_exec", {26'd0, dmem_req, alusrc, alu_operation}, {26'd0, 2'b01, 4'b0010});
        step();
        for (int i = 0; i < 4; i++) begin
            dmem_ready = (i == 3);
            #1;
            check("ld_mem_req", {29'd0, dmem_req, dmem_we, imem_req}, 32'b100);
            check("ld_mem_alu", {27'd0, alusrc, alu_operation}, {27'd0, 1'b1, 4'b0010});
            check("ld_mem_ctl", {29'd0, pc_en, regwrite, memtoreg},
                  (i == 3) ? 32'b111 : 32'b000);
            step();
        end
        dmem_ready = 1'b0;
        #1;
        check("ld_done", {30'd0, dmem_req, imem_req}, 32'b01);
        check("ld_instret", instret, 32'd6);

        // sd with one wait cycle
        do_fetch(I_SD);
        step();
        #1;
        check("sd_wait", {28'd0, dmem_req, dmem_we, regwrite, pc_en}, 32'b1100);
        step();
        dmem_ready = 1'b1;
        #1;
        check("sd_ready", {28'd0, dmem_req, dmem_we, regwrite, pc_en}, 32'b1101);
        step();
        dmem_ready = 1'b0;
        #1;
        check("sd_instret", instret, 32'd7);

        // unsupported ld width traps
        do_fetch(I_LW);
        #1;
        check("lw_trap", {30'd0, illegal, pc_en}, 32'b10);
        check("lw_instret", instret, 32'd7);
        do_reset();

        // all-ones IR: trap persists, fetch never resumes
        do_fetch(I_ONES);
        imem_ready = 1'b1;
        dmem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("ones_trap", {28'd0, illegal, imem_req, pc_en, dmem_req}, 32'b1000);
            step();
        end
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        #1;
        check("ones_instret", instret, 32'd0);
        do_reset();

        // reset during a MEM wait drops dmem_req at once and counts nothing
        do_fetch(I_LD);
        step();
        #1;
        check("rmem_req", {31'd0, dmem_req}, 32'd1);
        #1;
        reset = 1'b0;
        #1;
        check("rmem_drop", {29'd0, dmem_req, imem_req, pc_en}, 32'd0);
        step();
        reset = 1'b1;
        #1;
        check("rmem_after", {30'd0, imem_req, illegal}, 32'b10);
        check("rmem_instret", instret, 32'd0);
        check("rmem_ir", instruction, IR_NOP);

        // normal operation resumes
        do_fetch(I_ADD);
        step();
        step();
        #1;
        check("resume_instret", instret, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks_s, errors_s);
        $finish;
    end

endmodule
